rob_commit: RTL

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// ============================================================================
// Module      : rob_commit
// Description : Reorder-buffer commit stage. Circular buffer of 2^W-1 entries
//               with in-order issue, CDB writeback, single-entry commit,
//               branch-mispredict flush and two combinational operand queries.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_commit #(
   parameter int ROB_SIZE_WIDTH = 3
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   // issue side
   input  logic                      dec_valid,
   input  logic [1:0]                dec_type,
   input  logic [4:0]                dec_rd,
   input  logic                      dec_ready,
   input  logic [31:0]               dec_value,
   input  logic                      dec_pred_taken,
   input  logic [31:0]               dec_alt_pc,
   output logic                      rob_full_out,
   output logic [ROB_SIZE_WIDTH-1:0] dec_tag_out,
   // writeback
   input  logic                      cdb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
   input  logic [31:0]               cdb_value,
   input  logic                      cdb_taken,
   // register commit
   output logic                      rob_valid_out,
   output logic [4:0]                rob_rd_out,
   output logic [31:0]               rob_value_out,
   output logic [ROB_SIZE_WIDTH-1:0] rob_dependency_out,
   // store commit
   output logic                      store_commit_out,
   output logic [ROB_SIZE_WIDTH-1:0] store_tag_out,
   // flush
   output logic                      need_flush_out,
   output logic [31:0]               flush_pc_out,
   // operand queries
   input  logic [ROB_SIZE_WIDTH-1:0] qry1_tag,
   input  logic [ROB_SIZE_WIDTH-1:0] qry2_tag,
   output logic                      qry1_ready_out,
   output logic                      qry2_ready_out,
   output logic [31:0]               qry1_value_out,
   output logic [31:0]               qry2_value_out
);

   localparam int W     = ROB_SIZE_WIDTH;
   // Arrays span the reserved index too so any tag is a safe read; that slot
   // is never written and stays invalid.
   localparam int SLOTS = 2 ** W;

   localparam logic [W-1:0] C_TAG_NONE = {W{1'b1}};
   localparam logic [W-1:0] C_TAG_LAST = {{(W-1){1'b1}}, 1'b0};

   localparam logic [1:0] C_TYPE_REG    = 2'd0;
   localparam logic [1:0] C_TYPE_STORE  = 2'd1;
   localparam logic [1:0] C_TYPE_BRANCH = 2'd2;

   // entry storage
   logic        valid_q  [SLOTS];
   logic [1:0]  type_q   [SLOTS];
   logic [4:0]  rd_q     [SLOTS];
   logic        ready_q  [SLOTS];
   logic [31:0] value_q  [SLOTS];
   logic        pred_q   [SLOTS];
   logic        taken_q  [SLOTS];
   logic [31:0] alt_pc_q [SLOTS];

   // pointers
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [W-1:0] count_q, count_d;

   // registered pulse outputs
   logic         rob_valid_q;
   logic [4:0]   rob_rd_q;
   logic [31:0]  rob_value_q;
   logic [W-1:0] rob_dep_q;
   logic         store_commit_q;
   logic [W-1:0] store_tag_q;
   logic         need_flush_q;
   logic [31:0]  flush_pc_q;

   // per-edge decisions
   logic full;
   logic do_commit;
   logic mispredict;
   logic retire;
   logic do_issue;
   logic do_cdb;

   function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
      return (p == C_TAG_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full         = (count_q == C_TAG_NONE);
   assign rob_full_out = full;
   assign dec_tag_out  = tail_q;

   assign rob_valid_out      = rob_valid_q;
   assign rob_rd_out         = rob_rd_q;
   assign rob_value_out      = rob_value_q;
   assign rob_dependency_out = rob_dep_q;
   assign store_commit_out   = store_commit_q;
   assign store_tag_out      = store_tag_q;
   assign need_flush_out     = need_flush_q;
   assign flush_pc_out       = flush_pc_q;

   // Decide what happens at the coming edge; commit only sees readiness that
   // was already stored, so a CDB write never commits in the same edge.
   always_comb begin
      do_commit  = rdy_in && (count_q != '0) && valid_q[head_q] && ready_q[head_q];
      mispredict = do_commit && (type_q[head_q] == C_TYPE_BRANCH)
                   && (taken_q[head_q] != pred_q[head_q]);
      retire     = do_commit && !mispredict;
      // A full buffer still accepts an issue into the slot freed by a retire.
      do_issue   = rdy_in && !need_flush_q && !mispredict && dec_valid && (!full || retire);
      do_cdb     = rdy_in && !need_flush_q && !mispredict && cdb_valid
                   && (cdb_tag != C_TAG_NONE) && valid_q[cdb_tag];
   end

   // Next head/tail/count; a mispredict empties the buffer outright.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (mispredict) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (retire)   head_d = ptr_inc(head_q);
         if (do_issue) tail_d = ptr_inc(tail_q);
         case ({do_issue, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Entry array update: retire frees head, CDB fills results, issue writes
   // tail last so it wins when it reuses the slot just retired.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < SLOTS; i++) begin
            valid_q[i]  <= 1'b0;
            type_q[i]   <= '0;
            rd_q[i]     <= '0;
            ready_q[i]  <= 1'b0;
            value_q[i]  <= '0;
            pred_q[i]   <= 1'b0;
            taken_q[i]  <= 1'b0;
            alt_pc_q[i] <= '0;
         end
      end else if (rdy_in) begin
         if (mispredict) begin
            for (int i = 0; i < SLOTS; i++) begin
               valid_q[i] <= 1'b0;
            end
         end else begin
            if (retire) begin
               valid_q[head_q] <= 1'b0;
            end
            if (do_cdb) begin
               ready_q[cdb_tag] <= 1'b1;
               value_q[cdb_tag] <= cdb_value;
               taken_q[cdb_tag] <= cdb_taken;
            end
            if (do_issue) begin
               valid_q[tail_q]  <= 1'b1;
               type_q[tail_q]   <= dec_type;
               rd_q[tail_q]     <= dec_rd;
               ready_q[tail_q]  <= dec_ready;
               value_q[tail_q]  <= dec_value;
               pred_q[tail_q]   <= dec_pred_taken;
               // an entry issued ready has no outcome pending: retire as predicted
               taken_q[tail_q]  <= dec_pred_taken;
               alt_pc_q[tail_q] <= dec_alt_pc;
            end
         end
      end
   end

   // Pointer state and one-cycle commit/flush pulses.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         rob_valid_q    <= 1'b0;
         rob_rd_q       <= '0;
         rob_value_q    <= '0;
         rob_dep_q      <= '0;
         store_commit_q <= 1'b0;
         store_tag_q    <= '0;
         need_flush_q   <= 1'b0;
         flush_pc_q     <= '0;
      end else if (!rdy_in) begin
         rob_valid_q    <= 1'b0;
         rob_rd_q       <= '0;
         rob_value_q    <= '0;
         rob_dep_q      <= '0;
         store_commit_q <= 1'b0;
         store_tag_q    <= '0;
         need_flush_q   <= 1'b0;
         flush_pc_q     <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;

         if (retire && (type_q[head_q] == C_TYPE_REG)) begin
            rob_valid_q <= 1'b1;
            rob_rd_q    <= rd_q[head_q];
            rob_value_q <= value_q[head_q];
            rob_dep_q   <= head_q;
         end else begin
            rob_valid_q <= 1'b0;
            rob_rd_q    <= '0;
            rob_value_q <= '0;
            rob_dep_q   <= '0;
         end

         if (retire && (type_q[head_q] == C_TYPE_STORE)) begin
            store_commit_q <= 1'b1;
            store_tag_q    <= head_q;
         end else begin
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
         end

         need_flush_q <= mispredict;
         flush_pc_q   <= mispredict ? alt_pc_q[head_q] : '0;
      end
   end

   // Operand query 1: stored result, or the result on the CDB right now.
   always_comb begin
      qry1_ready_out = 1'b0;
      qry1_value_out = '0;
      if ((qry1_tag != C_TAG_NONE) && valid_q[qry1_tag]) begin
         if (cdb_valid && (cdb_tag == qry1_tag)) begin
            qry1_ready_out = 1'b1;
            qry1_value_out = cdb_value;
         end else if (ready_q[qry1_tag]) begin
            qry1_ready_out = 1'b1;
            qry1_value_out = value_q[qry1_tag];
         end
      end
   end

   // Operand query 2: same lookup as query 1.
   always_comb begin
      qry2_ready_out = 1'b0;
      qry2_value_out = '0;
      if ((qry2_tag != C_TAG_NONE) && valid_q[qry2_tag]) begin
         if (cdb_valid && (cdb_tag == qry2_tag)) begin
            qry2_ready_out = 1'b1;
            qry2_value_out = cdb_value;
         end else if (ready_q[qry2_tag]) begin
            qry2_ready_out = 1'b1;
            qry2_value_out = value_q[qry2_tag];
         end
      end
   end

endmodule

`default_nettype wire
